async_sram_ctrl: RTL

ASYNC_SRAM_CTRL -- requirements
Module: async_sram_ctrl

---
 rtl/async_sram_pkg.sv | 15 +
 rtl/sram_dq_tribuf.sv | 14 +
 rtl/async_sram_ctrl.sv | 135 +++++++++++++
 3 files changed

// File: rtl/async_sram_pkg.sv
// Shared types and default parameters for the asynchronous SRAM controller.
package async_sram_pkg;

   localparam int DW_DEF       = 16;
   localparam int AW_DEF       = 18;
   localparam int WAIT_CYC_DEF = 2;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      SETUP  = 2'd1,
      ACCESS = 2'd2,
      HOLD   = 2'd3
   } state_t;

endpackage

// File: rtl/sram_dq_tribuf.sv
// Bidirectional SRAM data pad: the single place where the dq bus is driven.
module sram_dq_tribuf #(
   parameter int DW = 16
) (
   input  logic          oe,
   input  logic [DW-1:0] dout,
   output logic [DW-1:0] din,
   inout  wire  [DW-1:0] pad
);

   assign pad = oe ? dout : {DW{1'bz}};
   assign din = pad;

endmodule

// File: rtl/async_sram_ctrl.sv
// Single-request asynchronous SRAM controller: SETUP / ACCESS / HOLD sequencing
// with every SRAM strobe driven straight from a flop.
//
// state  | meaning
// IDLE   | ready for a request; strobes high, lanes disabled, addr held
// SETUP  | addr/lanes/ce_n asserted (oe_n too for reads), one cycle
// ACCESS | we_n low + dq driven (write) or oe_n low (read), WAIT_CYC cycles
// HOLD   | we_n/oe_n released, ce_n and addr kept, write data kept on dq
module async_sram_ctrl
   import async_sram_pkg::*;
#(
   parameter int DW       = DW_DEF,
   parameter int AW       = AW_DEF,
   parameter int WAIT_CYC = WAIT_CYC_DEF
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            req_valid,
   output logic            req_ready,
   input  logic            req_we,
   input  logic [AW-1:0]   req_addr,
   input  logic [DW-1:0]   req_wdata,
   input  logic [DW/8-1:0] req_be,
   output logic            rsp_valid,
   output logic [DW-1:0]   rsp_rdata,
   output logic [AW-1:0]   sram_addr,
   inout  wire  [DW-1:0]   sram_dq,
   output logic            sram_ce_n,
   output logic            sram_oe_n,
   output logic            sram_we_n,
   output logic [DW/8-1:0] sram_be_n,
   output logic            busy
);

   localparam int CW = $clog2(WAIT_CYC + 1);

   state_t            state_q;
   logic [CW-1:0]     cnt_q;
   logic              we_q;
   logic [AW-1:0]     addr_q;
   logic [DW-1:0]     wdata_q;
   logic [DW-1:0]     rdata_q;
   logic [DW/8-1:0]   be_n_q;
   logic              ce_n_q;
   logic              oe_n_q;
   logic              we_n_q;
   logic              dq_oe_q;
   logic              rsp_valid_q;
   logic [DW-1:0]     dq_in;

   // Reset dominates, so a request is never taken in a cycle where rst is high.
   assign req_ready = (state_q == IDLE) && !rst;
   assign busy      = (state_q != IDLE);

   assign rsp_valid = rsp_valid_q;
   assign rsp_rdata = rdata_q;
   assign sram_addr = addr_q;
   assign sram_ce_n = ce_n_q;
   assign sram_oe_n = oe_n_q;
   assign sram_we_n = we_n_q;
   assign sram_be_n = be_n_q;

   sram_dq_tribuf #(
      .DW (DW)
   ) u_dq (
      .oe   (dq_oe_q),
      .dout (wdata_q),
      .din  (dq_in),
      .pad  (sram_dq)
   );

   // Sequencer: strobe levels for the next cycle are decided at the transition
   // into that cycle so the pins come directly from these flops.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= IDLE;
         cnt_q       <= '0;
         we_q        <= 1'b0;
         addr_q      <= '0;
         wdata_q     <= '0;
         rdata_q     <= '0;
         be_n_q      <= '1;
         ce_n_q      <= 1'b1;
         oe_n_q      <= 1'b1;
         we_n_q      <= 1'b1;
         dq_oe_q     <= 1'b0;
         rsp_valid_q <= 1'b0;
      end else begin
         rsp_valid_q <= 1'b0;
         case (state_q)
            IDLE: begin
               if (req_valid) begin
                  state_q <= SETUP;
                  we_q    <= req_we;
                  addr_q  <= req_addr;
                  wdata_q <= req_wdata;
                  be_n_q  <= req_we ? ~req_be : '0;
                  ce_n_q  <= 1'b0;
                  oe_n_q  <= req_we;
               end
            end
            SETUP: begin
               state_q <= ACCESS;
               cnt_q   <= CW'(WAIT_CYC);
               if (we_q) begin
                  we_n_q  <= 1'b0;
                  dq_oe_q <= 1'b1;
               end
            end
            ACCESS: begin
               if (cnt_q == CW'(1)) begin
                  state_q <= HOLD;
                  cnt_q   <= '0;
                  we_n_q  <= 1'b1;
                  oe_n_q  <= 1'b1;
                  if (!we_q) begin
                     rdata_q     <= dq_in;
                     rsp_valid_q <= 1'b1;
                  end
               end else begin
                  cnt_q <= cnt_q - CW'(1);
               end
            end
            HOLD: begin
               state_q <= IDLE;
               ce_n_q  <= 1'b1;
               be_n_q  <= '1;
               dq_oe_q <= 1'b0;
            end
            default: state_q <= IDLE;
         endcase
      end
   end

endmodule
